regfile_wr_arbiter: RTL
=======================

Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port between two writeback sources:
  - requester A: ALU/pipeline writeback.
  - requester B: long-latency load/multi-cycle unit.
- Fixed priority to A, with a starvation guard for B.
- Keeps a pending-write scoreboard for B destinations and raises hazard for decode.
- Sits between the writeback stages and the register file; drives its write_enable/addr_rd/data_rd inputs.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles B may be valid and refused before it gets priority (range 1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  A write request.
- a_ready  out  1  A accepted this cycle (combinational grant).
- a_rd  in  5  A destination register.
- a_data  in  32  A write data.
- b_valid  in  1  B write request.
- b_ready  out  1  B accepted this cycle (combinational grant).
- b_rd  in  5  B destination register.
- b_data  in  32  B write data.
- issue_valid  in  1  a long-latency op targeting issue_rd was issued this cycle.
- issue_rd  in  5  destination of the issued long-latency op.
- chk_rs1  in  5  decode source 1.
- chk_rs2  in  5  decode source 2.
- hazard  out  1  a source is pending in the scoreboard.
- sb_err  out  1  sticky protocol error.
- rf_we  out  1  register-file write enable (registered).
- rf_addr_rd  out  5  register-file write address (registered).
- rf_data_rd  out  32  register-file write data (registered).

Behaviour:
- Reset (async): rf_we=0, rf_addr_rd=0, rf_data_rd=0, busy[31:0]=0, starve_cnt=0, sb_err=0.
- Grant (combinational from current inputs and starve_cnt):
  - starve_cnt==STARVE_LIMIT and b_valid -> B granted, a_ready=0.
  - else a_valid -> A granted.
  - else b_valid -> B granted.
  - At most one grant per cycle; a_ready/b_ready are 0 when the matching valid is 0.
- Handshake: a transfer occurs on valid&ready at the posedge. Refused requesters hold rd/data stable until accepted.
- Write stage (1-cycle latency):
  - On a transfer, the next cycle has rf_we=1 with the granted rd/data.
  - With no transfer, rf_we=0; addr/data hold their last value.
  - The register file commits one edge later, so data is readable two cycles after acceptance.
- rd==0: the handshake completes normally, but rf_we stays 0.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle b_valid&!b_ready.
  - Clears when B is granted or b_valid==0.
- Scoreboard:
  - issue_valid with issue_rd!=0 sets busy[issue_rd].
  - An accepted B transfer clears busy[b_rd].
  - Set and clear of the same rd in the same cycle: set wins.
  - busy[0] is never set.
- hazard = (chk_rs1!=0 & busy[chk_rs1]) | (chk_rs2!=0 & busy[chk_rs2]). Evaluated combinationally from registered busy; same-cycle issue/clear is visible the next cycle.
- sb_err is set (sticky until reset) on either:
  - issue_valid to an rd already busy and not cleared in the same cycle;
  - an accepted B transfer whose b_rd!=0 and is not busy.
- Reset mid-operation: pending rf write dropped (rf_we=0 immediately), scoreboard and counter cleared.

Optional Feature:
- Macro: REGFILE_WR_FWD_EN.
- Defined: adds outputs fwd_rs1_hit, fwd_rs2_hit (1 bit each) and fwd_data_rs1, fwd_data_rs2 (32 bits each).
  - fwd_rsN_hit = rf_we & rf_addr_rd==chk_rsN & chk_rsN!=0.
  - fwd_data_rsN = rf_data_rd.
  - Lets decode bypass the in-flight write.
- Undefined: these ports do not exist; no extra logic.

Test Plan:
- A only: a_valid, rd=5, data=0xDEADBEEF -> a_ready=1 same cycle; next cycle rf_we=1, rf_addr_rd=5, rf_data_rd=0xDEADBEEF.
- Contention with STARVE_LIMIT=4: A and B valid continuously -> A granted 4 cycles, B granted on the 5th (a_ready=0); counter clears; A wins again after.
- Scoreboard: issue rd=7; chk_rs1=7 -> hazard=1 from the next cycle; B write rd=7 accepted -> hazard=0 the cycle after; chk_rs2=0 never raises hazard.
- rd=0 via A and B -> both handshakes complete, rf_we stays 0, busy unchanged.
- Errors: issue rd=3 twice with no B write -> sb_err=1 and stays 1; B write to non-busy rd=9 after reset -> sb_err=1.
- Async reset asserted mid-cycle during a pending write -> rf_we drops to 0 without a clock edge; busy=0, hazard=0. With REGFILE_WR_FWD_EN defined, chk_rs1 matching rf_addr_rd while rf_we=1 -> fwd_rs1_hit=1, fwd_data_rs1=rf_data_rd.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between ALU writeback (A) and a long-latency unit (B),
// with a starvation guard for B, a pending-write scoreboard for decode hazards, and optional bypass (REGFILE_WR_FWD_EN).
module regfile_wr_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    output logic        hazard,
    output logic        sb_err,
`ifdef REGFILE_WR_FWD_EN
    output logic        fwd_rs1_hit,
    output logic        fwd_rs2_hit,
    output logic [31:0] fwd_data_rs1,
    output logic [31:0] fwd_data_rs2,
`endif
    output logic        rf_we,
    output logic [4:0]  rf_addr_rd,
    output logic [31:0] rf_data_rd
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  r_starve_cnt;
    logic [31:0] r_busy;
    logic        r_sb_err;
    logic        r_rf_we;
    logic [4:0]  r_rf_addr;
    logic [31:0] r_rf_data;

    logic        w_starved;
    logic        w_grant_a;
    logic        w_grant_b;
    logic [4:0]  w_wr_rd;
    logic [31:0] w_wr_data;
    logic        w_set;
    logic        w_clr;
    logic        w_err_issue;
    logic        w_err_clr;
    logic [31:0] w_busy_nxt;

    // A starved B overrides A's fixed priority for exactly one grant.
    assign w_starved = (r_starve_cnt == LIMIT) && b_valid;
    assign w_grant_a = a_valid && !w_starved;
    assign w_grant_b = b_valid && (w_starved || !a_valid);
    assign a_ready   = w_grant_a;
    assign b_ready   = w_grant_b;

    assign w_wr_rd   = w_grant_b ? b_rd   : a_rd;
    assign w_wr_data = w_grant_b ? b_data : a_data;

    assign w_set = issue_valid && (issue_rd != 5'd0);
    assign w_clr = w_grant_b && (b_rd != 5'd0);

    assign w_err_issue = w_set && r_busy[issue_rd] && !(w_clr && (b_rd == issue_rd));
    assign w_err_clr   = w_clr && !r_busy[b_rd];

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) w_busy_nxt[b_rd] = 1'b0;
        if (w_set) w_busy_nxt[issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
            r_busy       <= 32'd0;
            r_sb_err     <= 1'b0;
            r_rf_we      <= 1'b0;
            r_rf_addr    <= 5'd0;
            r_rf_data    <= 32'd0;
        end else begin
            if (!b_valid || w_grant_b)
                r_starve_cnt <= 4'd0;
            else if (r_starve_cnt < LIMIT)
                r_starve_cnt <= r_starve_cnt + 4'd1;

            r_busy <= w_busy_nxt;
            if (w_err_issue || w_err_clr)
                r_sb_err <= 1'b1;

            // Writes to x0 complete the handshake but never reach the register file.
            r_rf_we <= (w_grant_a || w_grant_b) && (w_wr_rd != 5'd0);
            if ((w_grant_a || w_grant_b) && (w_wr_rd != 5'd0)) begin
                r_rf_addr <= w_wr_rd;
                r_rf_data <= w_wr_data;
            end
        end
    end

    assign hazard = ((chk_rs1 != 5'd0) && r_busy[chk_rs1]) ||
                    ((chk_rs2 != 5'd0) && r_busy[chk_rs2]);
    assign sb_err     = r_sb_err;
    assign rf_we      = r_rf_we;
    assign rf_addr_rd = r_rf_addr;
    assign rf_data_rd = r_rf_data;

`ifdef REGFILE_WR_FWD_EN
    assign fwd_rs1_hit  = r_rf_we && (r_rf_addr == chk_rs1) && (chk_rs1 != 5'd0);
    assign fwd_rs2_hit  = r_rf_we && (r_rf_addr == chk_rs2) && (chk_rs2 != 5'd0);
    assign fwd_data_rs1 = r_rf_data;
    assign fwd_data_rs2 = r_rf_data;
`endif

endmodule
